// File: rtl/imem_loader_if.sv
// Byte-stream handshake bundle between a program source and the instruction memory loader.
// Latency: none (wires only).
// Backpressure: byte_ready from the loader gates every byte. A byte transfers when byte_valid and byte_ready are both high.
interface imem_loader_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (output byte_valid, output byte_data, input byte_ready);
    modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/imem_loader.sv
// Loads a checksummed byte stream into the instruction RAM as little-endian words and holds the CPU in reset until the load is verified.
// Latency: a word is readable one cycle after its 4th byte. done appears one cycle after the checksum byte.
// Backpressure: byte_ready depends only on the registered state. The loader accepts one byte per cycle in HEADER, DATA and CHECK.
module imem_loader #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    imem_loader_if.slave        bus,
    input  logic [31:0]         pc,
    output logic [31:0]         instruction,
    output logic                cpu_reset,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        DATA   = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] word_idx;
    logic [AW-1:0] word_last;
    logic [1:0]    byte_idx;
    logic [7:0]    csum;
    logic [23:0]   asm_word;
    logic [31:0]   mem [DEPTH];
    logic          hs;
    logic          hdr_bad;
    logic [7:0]    hdr_minus1;
    logic          unused_pc;

    assign hs         = bus.byte_valid & bus.byte_ready;
    // A header of zero words is rejected, as is a count larger than the RAM.
    assign hdr_bad    = (bus.byte_data == 8'd0) || ({1'b0, bus.byte_data} > 9'(DEPTH));
    // The last word index is kept rather than the count, so the end-of-data test is a plain compare.
    assign hdr_minus1 = bus.byte_data - 8'd1;

    // The fetch port is always live. Only the word-address bits of pc matter.
    assign instruction = mem[pc[AW+1:2]];
    assign unused_pc   = ^{pc[31:AW+2], pc[1:0]};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic. start is only honoured outside an active session.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = HEADER;
            HEADER:  if (hs) state_nxt = hdr_bad ? ERROR : DATA;
            DATA:    if (hs && byte_idx == 2'd3 && word_idx == word_last) state_nxt = CHECK;
            CHECK:   if (hs) state_nxt = (bus.byte_data == csum) ? DONE : ERROR;
            DONE:    if (start) state_nxt = HEADER;
            ERROR:   if (start) state_nxt = HEADER;
            default: state_nxt = IDLE;
        endcase
    end

    // Status and ready are pure decodes of the state register, so there is no path from byte_valid to byte_ready.
    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        error          = 1'b0;
        cpu_reset      = 1'b1;
        bus.byte_ready = 1'b0;
        case (state)
            HEADER, DATA, CHECK: begin
                busy           = 1'b1;
                bus.byte_ready = 1'b1;
            end
            DONE:    begin
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            ERROR:   error = 1'b1;
            default: ;
        endcase
    end

    // Session counters, running checksum and the word assembly register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_idx  <= '0;
            word_last <= '0;
            byte_idx  <= 2'd0;
            csum      <= 8'd0;
            asm_word  <= 24'd0;
        end else if (hs) begin
            if (state == HEADER && !hdr_bad) begin
                word_last <= hdr_minus1[AW-1:0];
                word_idx  <= '0;
                byte_idx  <= 2'd0;
                csum      <= 8'd0;
            end else if (state == DATA) begin
                case (byte_idx)
                    2'd0:    asm_word[7:0]   <= bus.byte_data;
                    2'd1:    asm_word[15:8]  <= bus.byte_data;
                    2'd2:    asm_word[23:16] <= bus.byte_data;
                    default: word_idx        <= word_idx + 1'b1;
                endcase
                csum     <= csum ^ bus.byte_data;
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    // Instruction RAM. Reset refills it with NOPs. Words are committed on their 4th byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= NOP;
        end else if (hs && state == DATA && byte_idx == 2'd3) begin
            mem[word_idx] <= {bus.byte_data, asm_word};
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a vector table for whole sessions, plus hand-written stall and async-reset sequences.
// Latency: checks are sampled 1 time unit after each rising edge.
// Backpressure: the bench drives byte_valid and pauses the stream to exercise stalls.
module tb_imem_loader;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] W0  = 32'h00100093;
    localparam logic [31:0] W1  = 32'h00200113;
    // Flag order: {byte_ready, busy, done, error, cpu_reset}
    localparam logic [4:0]  FI  = 5'b00001;
    localparam logic [4:0]  FB  = 5'b11001;
    localparam logic [4:0]  FD  = 5'b00100;
    localparam logic [4:0]  FE  = 5'b00011;

    typedef struct {
        logic        st;
        logic        vld;
        logic [7:0]  dat;
        logic [31:0] pc;
        logic [4:0]  flags;
        logic [31:0] instr;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader_if bus ();

    imem_loader #(.DEPTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .bus         (bus),
        .pc          (pc),
        .instruction (instruction),
        .cpu_reset   (cpu_reset),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests;
    int          fails;
    vec_t        vecs[64];
    int          nvec;
    logic [7:0]  gb[10];
    logic [4:0]  flags_now;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic vld, input logic [7:0] dat,
                       input logic [31:0] p, input logic [4:0] f, input logic [31:0] ins);
        vecs[nvec] = '{st, vld, dat, p, f, ins};
        nvec++;
    endtask

    // One full session while mem[0] already holds W0. Only the checksum byte and the final flags vary.
    task automatic add_load(input logic [7:0] ck, input logic [4:0] fin);
        add(1'b1, 1'b0, 8'h00, 32'd0, FB, W0);
        for (int k = 0; k < 9; k++) add(1'b0, 1'b1, gb[k], 32'd0, FB, W0);
        add(1'b0, 1'b1, ck, 32'd4, fin, W1);
    endtask

    function automatic logic [4:0] get_flags();
        return {bus.byte_ready, busy, done, error, cpu_reset};
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        nvec  = 0;
        gb    = '{8'h02, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00, 8'hB1};

        reset          = 1'b1;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        pc             = 32'd0;

        // Reset state
        #12;
        check("rst_flags", 32'(get_flags()), 32'(FI));
        check("rst_pc0", instruction, NOP);
        pc = 32'd4;   #1; check("rst_pc4", instruction, NOP);
        pc = 32'd124; #1; check("rst_pc124", instruction, NOP);
        pc = 32'd0;
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_flags", 32'(get_flags()), 32'(FI));

        // Good load with word-write timing visible on the fetch port
        add(1'b1, 1'b0, 8'h00, 32'd0, FB, NOP);
        add(1'b0, 1'b0, 8'h55, 32'd0, FB, NOP);
        add(1'b0, 1'b1, 8'h02, 32'd0, FB, NOP);
        add(1'b0, 1'b1, 8'h93, 32'd0, FB, NOP);
        add(1'b0, 1'b1, 8'h00, 32'd0, FB, NOP);
        add(1'b0, 1'b1, 8'h10, 32'd0, FB, NOP);
        add(1'b0, 1'b1, 8'h00, 32'd0, FB, W0);
        add(1'b0, 1'b1, 8'h13, 32'd4, FB, NOP);
        add(1'b0, 1'b1, 8'h01, 32'd4, FB, NOP);
        add(1'b0, 1'b1, 8'h20, 32'd4, FB, NOP);
        add(1'b0, 1'b1, 8'h00, 32'd4, FB, W1);
        add(1'b0, 1'b1, 8'hB1, 32'd4, FD, W1);
        add(1'b0, 1'b0, 8'h00, 32'd8, FD, NOP);
        // Bad length: zero, then DEPTH+1. Memory must be left alone.
        add(1'b1, 1'b0, 8'h00, 32'd0, FB, W0);
        add(1'b0, 1'b1, 8'h00, 32'd0, FE, W0);
        add(1'b0, 1'b1, 8'h77, 32'd4, FE, W1);
        add(1'b1, 1'b0, 8'h00, 32'd0, FB, W0);
        add(1'b0, 1'b1, 8'h21, 32'd4, FE, W1);
        // Bad checksum, then the same stream with the correct checksum
        add_load(8'hB0, FE);
        add_load(8'hB1, FD);

        for (int i = 0; i < nvec; i++) begin
            start          = vecs[i].st;
            bus.byte_valid = vecs[i].vld;
            bus.byte_data  = vecs[i].dat;
            pc             = vecs[i].pc;
            @(posedge clk); #1;
            check($sformatf("vec%0d_flags", i), 32'(get_flags()), 32'(vecs[i].flags));
            check($sformatf("vec%0d_instr", i), instruction, vecs[i].instr);
        end
        start          = 1'b0;
        bus.byte_valid = 1'b0;

        // Stalls and an ignored start, from a freshly reset memory
        #3 reset = 1'b1;
        #2 reset = 1'b0;
        pc = 32'd0; #1;
        check("stall_pre_mem0", instruction, NOP);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("stall_hdr_ready", 32'(bus.byte_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            int nst;
            nst = (i == 2 || i == 5 || i == 8) ? int'($urandom_range(1, 3)) : 0;
            for (int s = 0; s < nst; s++) begin
                bus.byte_valid = 1'b0;
                bus.byte_data  = 8'($urandom);
                start          = (i == 5 && s == 0);
                @(posedge clk); #1;
                start = 1'b0;
                flags_now = get_flags();
                check($sformatf("stall%0d_hold", i), 32'(flags_now), 32'(FB));
            end
            bus.byte_valid = 1'b1;
            bus.byte_data  = gb[i];
            @(posedge clk); #1;
            bus.byte_valid = 1'b0;
            check($sformatf("stall_hs%0d_done", i + 1), 32'(done), (i == 9) ? 32'd1 : 32'd0);
        end
        check("stall_cpu_reset", 32'(cpu_reset), 32'd0);
        pc = 32'd0; #1; check("stall_mem0", instruction, W0);
        pc = 32'd4; #1; check("stall_mem1", instruction, W1);
        pc = 32'd8; #1; check("stall_mem2", instruction, NOP);

        // Async reset in the middle of DATA, after word 0 has been committed
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = gb[i];
            @(posedge clk); #1;
        end
        bus.byte_valid = 1'b0;
        pc = 32'd0;
        check("mid_busy", 32'(get_flags()), 32'(FB));
        check("mid_mem0", instruction, W0);
        #3 reset = 1'b1;
        #1;
        check("arst_flags", 32'(get_flags()), 32'(FI));
        check("arst_mem0", instruction, NOP);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        check("arst_idle", 32'(get_flags()), 32'(FI));
        pc = 32'd4; #1; check("arst_mem1", instruction, NOP);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
